ni_rx_depacketizer: RTL and testbench

NI_RX_DEPACKETIZER -- requirements
Module: ni_rx_depacketizer

---
 rtl/ni_rx_depacketizer.sv | 182 ++++++++++++++++++
 tb/tb_ni_rx_depacketizer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ni_rx_depacketizer.sv
// Network-interface receive side: strips router flits into payload words and streams
// them into the register file NI port, deferring to processor writes.
module ni_rx_depacketizer #(
   parameter logic [7:0] NODE_ID    = 8'd0,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [33:0] flit_in,
   input  logic        flit_valid,
   output logic        flit_ready,
   input  logic        cpu_we,
   output logic        reg_en,
   output logic [31:0] wd_NI,
   output logic        pkt_done,
   output logic        pkt_err
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, BODY, DROP, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [2:0]    count_q, count_d;
   logic [2:0]    len_q, len_d;
   logic          err_q, err_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   occ_q, occ_d;
   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [31:0]   mem_d [FIFO_DEPTH];
   logic          reg_en_q, reg_en_d;
   logic [31:0]   wd_q, wd_d;
   logic          pkt_done_q, pkt_done_d;
   logic          pkt_err_q, pkt_err_d;

   logic [1:0]    flit_type;
   logic [3:0]    hdr_len;
   logic          is_head, is_body, is_tail;
   logic          hdr_ok, hdr_bad_len;
   logic          accept, push, pop;
   logic          fifo_full, fifo_empty;
   logic [3:0]    cnt_inc;

   assign flit_type   = flit_in[33:32];
   assign hdr_len     = flit_in[11:8];
   assign is_head     = (flit_type == 2'b01);
   assign is_body     = (flit_type == 2'b00);
   assign is_tail     = (flit_type == 2'b10);
   assign hdr_ok      = (flit_in[7:0] == NODE_ID) && (hdr_len != 4'd0) && (hdr_len <= 4'd7);
   assign hdr_bad_len = (flit_in[7:0] == NODE_ID) && !hdr_ok;
   assign fifo_full   = (occ_q == DEPTH);
   assign fifo_empty  = (occ_q == '0);
   assign accept      = flit_valid && flit_ready;
   assign pop         = !fifo_empty && !cpu_we;
   assign cnt_inc     = {1'b0, count_q} + 4'd1;

   // Packet-framing FSM; a head seen mid-packet restarts framing but leaves queued words alone.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      len_d      = len_q;
      err_d      = err_q;
      push       = 1'b0;
      pkt_err_d  = 1'b0;
      pkt_done_d = 1'b0;
      flit_ready = 1'b1;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_head) begin
                  count_d   = '0;
                  len_d     = hdr_len[2:0];
                  err_d     = 1'b0;
                  state_d   = hdr_ok ? BODY : DROP;
                  pkt_err_d = hdr_bad_len;
               end else begin
                  pkt_err_d = 1'b1;
               end
            end
         end
         BODY: begin
            flit_ready = !fifo_full;
            if (accept) begin
               if (is_head) begin
                  count_d   = '0;
                  len_d     = hdr_len[2:0];
                  err_d     = 1'b0;
                  state_d   = hdr_ok ? BODY : DROP;
                  pkt_err_d = 1'b1;
               end else if (is_body) begin
                  if (cnt_inc == {1'b0, len_q}) begin
                     pkt_err_d = 1'b1;
                     state_d   = DROP;
                  end else begin
                     push    = 1'b1;
                     count_d = cnt_inc[2:0];
                  end
               end else if (is_tail) begin
                  push    = 1'b1;
                  count_d = cnt_inc[2:0];
                  state_d = DRAIN;
                  if (cnt_inc != {1'b0, len_q}) begin
                     err_d     = 1'b1;
                     pkt_err_d = 1'b1;
                  end
               end else begin
                  pkt_err_d = 1'b1;
                  state_d   = DROP;
               end
            end
         end
         DROP: begin
            if (accept && is_tail) state_d = IDLE;
         end
         DRAIN: begin
            flit_ready = 1'b0;
            // Empty here means the final pop already happened, so its reg_en is this cycle.
            if (fifo_empty) begin
               state_d    = IDLE;
               pkt_done_d = !err_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Payload FIFO and registered write port toward the register file.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q + (AW+1)'(push) - (AW+1)'(pop);
      reg_en_d = pop;
      wd_d     = wd_q;
      if (push) begin
         mem_d[wr_ptr_q] = flit_in[31:0];
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         wd_d     = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         len_q      <= '0;
         err_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         mem_q      <= '{default: '0};
         reg_en_q   <= 1'b0;
         wd_q       <= '0;
         pkt_done_q <= 1'b0;
         pkt_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         len_q      <= len_d;
         err_q      <= err_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         mem_q      <= mem_d;
         reg_en_q   <= reg_en_d;
         wd_q       <= wd_d;
         pkt_done_q <= pkt_done_d;
         pkt_err_q  <= pkt_err_d;
      end
   end

   assign reg_en   = reg_en_q;
   assign wd_NI    = wd_q;
   assign pkt_done = pkt_done_q;
   assign pkt_err  = pkt_err_q;

endmodule

// File: tb/tb_ni_rx_depacketizer.sv
// Directed scoreboard bench for ni_rx_depacketizer: expected payload words are queued
// as flits are driven and matched against each register-file write.
module tb_ni_rx_depacketizer;

   localparam logic [1:0] HEAD = 2'b01;
   localparam logic [1:0] BODYT = 2'b00;
   localparam logic [1:0] TAIL = 2'b10;

   logic        clk = 1'b0;
   logic        rst;
   logic [33:0] flit_in;
   logic        flit_valid;
   logic        flit_ready;
   logic        cpu_we;
   logic        reg_en;
   logic [31:0] wd_NI;
   logic        pkt_done;
   logic        pkt_err;

   int checks = 0;
   int failures = 0;
   int writeCount = 0;
   int doneCount = 0;
   int errCount = 0;
   int writeBase, doneBase, errBase;
   logic [31:0] sb[$];

   ni_rx_depacketizer #(.NODE_ID(8'd0), .FIFO_DEPTH(4)) dut (
      .clk(clk),
      .rst(rst),
      .flit_in(flit_in),
      .flit_valid(flit_valid),
      .flit_ready(flit_ready),
      .cpu_we(cpu_we),
      .reg_en(reg_en),
      .wd_NI(wd_NI),
      .pkt_done(pkt_done),
      .pkt_err(pkt_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one flit and hold it until the DUT takes it; queue the word if it should be written.
   task automatic applyStimulus(input logic [1:0] ftype, input logic [31:0] data, input bit expectWrite);
      bit accepted = 1'b0;
      @(negedge clk);
      flit_in    = {ftype, data};
      flit_valid = 1'b1;
      for (int i = 0; i < 200 && !accepted; i++) begin
         if (flit_ready) begin
            if (expectWrite) sb.push_back(data);
            @(posedge clk);
            accepted = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!accepted) checkOutput("accept_timeout", 32'(flit_ready), 32'd1);
      #1 flit_valid = 1'b0;
   endtask

   task automatic sendHead(input logic [7:0] dest, input logic [3:0] len);
      applyStimulus(HEAD, {20'h0, len, dest}, 1'b0);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic snapshot();
      writeBase = writeCount;
      doneBase  = doneCount;
      errBase   = errCount;
   endtask

   task automatic checkDeltas(input string tag, input int writes, input int dones, input int errs);
      checkOutput({tag, "_writes"}, 32'(writeCount - writeBase), 32'(writes));
      checkOutput({tag, "_done"}, 32'(doneCount - doneBase), 32'(dones));
      checkOutput({tag, "_err"}, 32'(errCount - errBase), 32'(errs));
      checkOutput({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
   endtask

   // Register-file side monitor: every write must match the oldest queued word.
   always @(negedge clk) begin
      if (!rst) begin
         if (reg_en) begin
            writeCount++;
            checkOutput("write_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) checkOutput("wd_NI", wd_NI, sb.pop_front());
         end
         if (pkt_done) doneCount++;
         if (pkt_err) errCount++;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      flit_valid = 1'b0;
      flit_in    = '0;
      cpu_we     = 1'b0;
      #3;
      checkOutput("rst_reg_en", 32'(reg_en), 32'd0);
      checkOutput("rst_wd_NI", wd_NI, 32'd0);
      checkOutput("rst_pkt_done", 32'(pkt_done), 32'd0);
      checkOutput("rst_pkt_err", 32'(pkt_err), 32'd0);
      checkOutput("rst_flit_ready", 32'(flit_ready), 32'd1);
      settle(2);
      rst = 1'b0;
      settle(1);

      // Basic three-word packet, back to back.
      snapshot();
      sendHead(8'h00, 4'd3);
      applyStimulus(BODYT, 32'hA1, 1'b1);
      applyStimulus(BODYT, 32'hA2, 1'b1);
      applyStimulus(TAIL, 32'hA3, 1'b1);
      settle(6);
      checkDeltas("basic", 3, 1, 0);

      // Processor writes hold off the NI port; order must survive the stall.
      snapshot();
      cpu_we = 1'b1;
      sendHead(8'h00, 4'd3);
      applyStimulus(BODYT, 32'hC1, 1'b1);
      applyStimulus(BODYT, 32'hC2, 1'b1);
      applyStimulus(TAIL, 32'hC3, 1'b1);
      settle(2);
      checkOutput("stall_reg_en", 32'(reg_en), 32'd0);
      checkOutput("stall_no_writes", 32'(writeCount - writeBase), 32'd0);
      cpu_we = 1'b0;
      settle(8);
      checkDeltas("stall", 3, 1, 0);

      // Packet for another node is swallowed silently.
      snapshot();
      sendHead(8'h05, 4'd2);
      applyStimulus(BODYT, 32'hE1, 1'b0);
      applyStimulus(TAIL, 32'hE2, 1'b0);
      settle(4);
      checkDeltas("other_node", 0, 0, 0);
      checkOutput("other_node_ready", 32'(flit_ready), 32'd1);

      // Early tail: words written, error flagged, no done.
      snapshot();
      sendHead(8'h00, 4'd3);
      applyStimulus(BODYT, 32'hB1, 1'b1);
      applyStimulus(TAIL, 32'hB2, 1'b1);
      settle(6);
      checkDeltas("short", 2, 0, 1);

      // Maximum-length packet into a stalled FIFO fills it and backpressures.
      snapshot();
      cpu_we = 1'b1;
      sendHead(8'h00, 4'd7);
      for (int i = 1; i <= 4; i++) applyStimulus(BODYT, 32'h70 + 32'(i), 1'b1);
      settle(1);
      checkOutput("full_ready", 32'(flit_ready), 32'd0);
      checkOutput("full_reg_en", 32'(reg_en), 32'd0);
      cpu_we = 1'b0;
      applyStimulus(BODYT, 32'h75, 1'b1);
      applyStimulus(BODYT, 32'h76, 1'b1);
      applyStimulus(TAIL, 32'h77, 1'b1);
      settle(10);
      checkDeltas("max_len", 7, 1, 0);

      // Reset mid-packet discards buffered words; stray flits afterward are errors.
      cpu_we = 1'b1;
      sendHead(8'h00, 4'd5);
      applyStimulus(BODYT, 32'hD1, 1'b0);
      applyStimulus(BODYT, 32'hD2, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("midrst_reg_en", 32'(reg_en), 32'd0);
      checkOutput("midrst_ready", 32'(flit_ready), 32'd1);
      settle(2);
      rst    = 1'b0;
      cpu_we = 1'b0;
      snapshot();
      applyStimulus(BODYT, 32'hF1, 1'b0);
      applyStimulus(TAIL, 32'hF2, 1'b0);
      settle(6);
      checkDeltas("after_rst", 0, 0, 2);

      // Body flit past the declared length is dropped along with the rest of the packet.
      snapshot();
      sendHead(8'h00, 4'd2);
      applyStimulus(BODYT, 32'h91, 1'b1);
      applyStimulus(BODYT, 32'h92, 1'b0);
      applyStimulus(TAIL, 32'h93, 1'b0);
      settle(6);
      checkDeltas("overflow", 1, 0, 1);
      checkOutput("overflow_ready", 32'(flit_ready), 32'd1);

      // Head arriving mid-packet restarts framing; earlier word still written.
      snapshot();
      sendHead(8'h00, 4'd3);
      applyStimulus(BODYT, 32'h61, 1'b1);
      sendHead(8'h00, 4'd1);
      applyStimulus(TAIL, 32'h62, 1'b1);
      settle(6);
      checkDeltas("rehead", 2, 1, 1);

      // Illegal lengths 0 and 8 are dropped with an error each.
      snapshot();
      sendHead(8'h00, 4'd0);
      applyStimulus(TAIL, 32'h51, 1'b0);
      sendHead(8'h00, 4'd8);
      applyStimulus(BODYT, 32'h52, 1'b0);
      applyStimulus(TAIL, 32'h53, 1'b0);
      settle(6);
      checkDeltas("bad_len", 0, 0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
